// File: rtl/intr_ctrl.sv
// Interrupt controller: six sources, fixed lowest-index priority, CTRL/MODE/PEND/CLAIM registers.
// Define INTR_CTRL_EDGE_EN to build in per-source edge detection selected by MODE.
module intr_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  irq_in,
   input  logic [1:0]  dev_addr,
   input  logic [31:0] dev_wd,
   input  logic        we,
   input  logic        re,
   output logic [31:0] dev_rd,
   output logic        irq_out
);
   localparam int unsigned NSRC = 6;
   localparam int unsigned IDW  = 3;

   localparam logic [1:0] A_CTRL  = 2'd0;
   localparam logic [1:0] A_MODE  = 2'd1;
   localparam logic [1:0] A_PEND  = 2'd2;
   localparam logic [1:0] A_CLAIM = 2'd3;

   typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, INSVC = 2'd2} state_t;

   state_t          state;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] mode;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] pend_next;
   logic [NSRC-1:0] eligible;
   logic            gie;
   logic [IDW-1:0]  isr_id;
   logic [IDW-1:0]  top_id;
   logic            claim;
   logic            done;
   logic            unused_wd;

   assign eligible  = gie ? (pend & mask) : '0;
   assign claim     = re && (dev_addr == A_CLAIM) && (state == ASSERT) && (|eligible);
   assign done      = we && (dev_addr == A_CLAIM) && (state == INSVC);
   assign unused_wd = ^{dev_wd[31:9], dev_wd[7:6]};

   // Lowest eligible index wins: scan downwards so the last hit is the smallest.
   always_comb begin
      top_id = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (eligible[i]) top_id = IDW'(i);
      end
   end

`ifdef INTR_CTRL_EDGE_EN
   logic [NSRC-1:0] prev;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] clr;

   // Edge sources set on a rise and clear by W1C or by a claim; a set beats a clear.
   always_comb begin
      rise = irq_in & ~prev;
      clr  = (we && (dev_addr == A_PEND)) ? dev_wd[NSRC-1:0] : '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (claim && (top_id == IDW'(i))) clr[i] = 1'b1;
      end
      pend_next = (mode & (rise | (pend & ~clr))) | (~mode & irq_in);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev <= '0;
         mode <= '0;
      end else begin
         prev <= irq_in;
         if (we && (dev_addr == A_MODE)) mode <= dev_wd[NSRC-1:0];
      end
   end
`else
   assign mode      = '0;
   assign pend_next = irq_in;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask <= '0;
         gie  <= 1'b0;
         pend <= '0;
      end else begin
         pend <= pend_next;
         if (we && (dev_addr == A_CTRL)) begin
            mask <= dev_wd[NSRC-1:0];
            gie  <= dev_wd[8];
         end
      end
   end

   // Request FSM; irq_out is high exactly while in ASSERT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         irq_out <= 1'b0;
         isr_id  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|eligible) begin
                  state   <= ASSERT;
                  irq_out <= 1'b1;
               end
            end
            ASSERT: begin
               if (claim) begin
                  state   <= INSVC;
                  irq_out <= 1'b0;
                  isr_id  <= top_id;
               end else if (!(|eligible)) begin
                  state   <= IDLE;
                  irq_out <= 1'b0;
               end
            end
            INSVC: begin
               irq_out <= 1'b0;
               if (done) state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               irq_out <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      dev_rd = '0;
      case (dev_addr)
         A_CTRL:  dev_rd = {16'd0, (state == INSVC), isr_id, 3'd0, gie, 2'd0, mask};
         A_MODE:  dev_rd = {26'd0, mode};
         A_PEND:  dev_rd = {26'd0, pend};
         A_CLAIM: begin
            if ((state == ASSERT) && (|eligible)) dev_rd = {1'b1, 28'd0, top_id};
         end
         default: dev_rd = '0;
      endcase
   end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port irq_in, input, 6, interrupt sources; bit 0 is timer0 IRQ, bit 1 is timer1 IRQ, bits 5:2 are spare.
REQ-004 SHALL have port dev_addr, input, 2, register select (byte address bits 3:2).
REQ-005 SHALL have port dev_wd, input, 32, write data from the bridge.
REQ-006 SHALL have port we, input, 1, register write enable from the bridge.
REQ-007 SHALL have port re, input, 1, register read strobe; one cycle per CPU load.
REQ-008 SHALL have port dev_rd, output, 32, read data, combinational on dev_addr.
REQ-009 SHALL have port irq_out, output, 1, registered request that drives HWInt[2].

Function
REQ-010 SHALL map registers as follows: 0 CTRL (bits 5:0 mask, bit 8 GIE, read-only bit 15 in_service, read-only bits 14:12 isr_id); 1 MODE (bits 5:0, 1=edge, 0=level); 2 PEND (read pending, write-1-to-clear); 3 CLAIM.
REQ-011 SHALL fix priority statically: lower index wins; eligible = pending & mask, gated by GIE.
REQ-012 SHALL, for a level source, load its pending bit from irq_in every cycle (one-cycle latency), with W1C having no effect on it.
REQ-013 SHALL, for an edge source, set its pending bit on the cycle after irq_in rises (stored previous sample 0, current 1), and clear it by PEND W1C or by a CLAIM of that id; a set and a clear in the same cycle leave it set.
REQ-014 SHALL run an FSM with states IDLE, ASSERT and INSVC.
REQ-015 SHALL move IDLE->ASSERT when eligible is nonzero; irq_out is 1 exactly in ASSERT, so it rises one cycle after eligibility.
REQ-016 SHALL return from ASSERT to IDLE, with no claim, if eligible becomes zero (mask write, GIE clear, or source drop).
REQ-017 SHALL, on a CLAIM read (re with dev_addr=3) in ASSERT: return bit 31=1 and bits 2:0=the highest-priority eligible id; latch that id into isr_id; clear its pending bit if it is edge; move to INSVC.
REQ-018 SHALL, on a CLAIM read in IDLE or INSVC, return 0x0000_0000 with no state change.
REQ-019 SHALL hold irq_out at 0 in INSVC (no nesting); new pending bits still accumulate.
REQ-020 SHALL, on any write to CLAIM in INSVC, move to IDLE the next cycle; a still-eligible source re-asserts irq_out one cycle after that.
REQ-021 SHALL ignore writes to CLAIM in IDLE and ASSERT.
REQ-022 SHALL read zero from unused register bits; writes to unused bits have no effect.
REQ-023 SHALL give a simultaneous we and re on the same address the write effect plus the pre-write read data.

Reset
REQ-024 SHALL, while reset=0, force irq_out=0, CTRL=0, MODE=0, PEND=0, previous samples=0, isr_id=0 and the FSM to IDLE, regardless of clk.
REQ-025 SHALL discard any in-flight claim when reset is asserted mid-service; after release there is no interrupt until a new source event and GIE=1.

Configuration
REQ-026 SHALL compile edge detection in when macro INTR_CTRL_EDGE_EN is defined: MODE is writable and REQ-013 applies.
REQ-027 SHALL, without INTR_CTRL_EDGE_EN, treat all sources as level, make MODE read 0 and ignore writes to it, implement no previous-sample registers, and make PEND W1C a no-op.

Verification
REQ-028 SHALL cover: CTRL=0x103, level irq_in[1]=1 -> irq_out=1 two cycles later; CLAIM read=0x8000_0001; irq_out=0; CLAIM write -> irq_out=1 again while the source is held.
REQ-029 SHALL cover: irq_in[0] and irq_in[1] rise together, CTRL=0x103 -> CLAIM returns id 0 first; after completion, id 1.
REQ-030 SHALL cover (EDGE_EN): MODE=0x01, one-cycle pulse on irq_in[0] -> PEND=0x01; CLAIM clears PEND to 0; a second pulse during INSVC sets PEND but irq_out stays 0 until the CLAIM write.
REQ-031 SHALL cover: ASSERT state, then CTRL write 0x100 (mask 0) -> irq_out=0 next cycle; a subsequent CLAIM read returns 0.
REQ-032 SHALL cover: reset=0 asserted while in INSVC -> all registers 0 and irq_out=0 immediately, with no dependence on clk.
REQ-033 SHALL cover: edge PEND W1C of 0x01 in the same cycle as a new rising edge -> PEND bit 0 remains 1.
